pic_rst_seq: RTL

//  Parametrised clock-lock reset sequencer and clock-enable prescaler for the PIC16 SoC top level.
//  It qualifies the clock-manager LOCKED signal and releases NCH reset domains one at a time
//  (core, peripherals, ...). It also provides a divided clock-enable for slow peripherals.
//  On loss of lock or a software request, all domains go back to reset.

---
 rtl/pic_rst_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pic_rst_seq.sv
// Clock-lock reset sequencer: qualifies a synchronised LOCKED, releases NCH reset domains in
// order, and generates a prescaled clock-enable once every domain is running.
module pic_rst_seq #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned LOCK_CYC  = 16,
    parameter int unsigned STAGE_CYC = 8,
    parameter int unsigned CEN_DIV   = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           LOCKED,
    input  logic           SWRST,
    output logic [NCH-1:0] RST_OUT,
    output logic           READY,
    output logic           CEN,
    output logic           LOCK_LOST,
    output logic [1:0]     STATE
);

    localparam int unsigned LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam int unsigned SW = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;
    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PW = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           lk_s1_q, lk_s_q;
    logic [LW-1:0]  lock_cnt_q, lock_cnt_d;
    logic [SW-1:0]  stage_cnt_q, stage_cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [NCH-1:0] rst_out_q, rst_out_d;
    logic           cen_q, cen_d;
    logic           lock_lost_q, lock_lost_d;
    logic           go_hold;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lk_s1_q     <= 1'b0;
            lk_s_q      <= 1'b0;
            state_q     <= StHold;
            lock_cnt_q  <= '0;
            stage_cnt_q <= '0;
            idx_q       <= '0;
            presc_q     <= '0;
            rst_out_q   <= '1;
            cen_q       <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            lk_s1_q     <= LOCKED;
            lk_s_q      <= lk_s1_q;
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            idx_q       <= idx_d;
            presc_q     <= presc_d;
            rst_out_q   <= rst_out_d;
            cen_q       <= cen_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        stage_cnt_d = stage_cnt_q;
        idx_d       = idx_q;
        presc_d     = presc_q;
        rst_out_d   = rst_out_q;
        cen_d       = 1'b0;
        lock_lost_d = lock_lost_q;
        go_hold     = 1'b0;

        if (SWRST && lk_s_q) begin
            lock_lost_d = 1'b0;
        end

        unique case (state_q)
            StHold: begin
                rst_out_d   = '1;
                stage_cnt_d = '0;
                idx_d       = '0;
                presc_d     = '0;
                if (SWRST || !lk_s_q) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LW'(LOCK_CYC - 1)) begin
                    lock_cnt_d = '0;
                    state_d    = StRelease;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            StRelease, StRun: begin
                // Lock loss outranks SWRST so a simultaneous request still flags the loss.
                if (!lk_s_q) begin
                    go_hold     = 1'b1;
                    lock_lost_d = 1'b1;
                end else if (SWRST) begin
                    go_hold = 1'b1;
                end else if (state_q == StRelease) begin
                    if (stage_cnt_q == SW'(STAGE_CYC - 1)) begin
                        stage_cnt_d = '0;
                        for (int i = 0; i < NCH; i++) begin
                            if (IW'(i) == idx_q) rst_out_d[i] = 1'b0;
                        end
                        if (idx_q == IW'(NCH - 1)) begin
                            idx_d   = '0;
                            state_d = StRun;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        stage_cnt_d = stage_cnt_q + 1'b1;
                    end
                end else begin
                    rst_out_d = '0;
                    if (presc_q == PW'(CEN_DIV - 1)) begin
                        presc_d = '0;
                        cen_d   = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            default: go_hold = 1'b1;
        endcase

        if (go_hold) begin
            state_d     = StHold;
            rst_out_d   = '1;
            lock_cnt_d  = '0;
            stage_cnt_d = '0;
            idx_d       = '0;
            presc_d     = '0;
            cen_d       = 1'b0;
        end
    end

    assign RST_OUT   = rst_out_q;
    assign READY     = (state_q == StRun);
    assign CEN       = cen_q;
    assign LOCK_LOST = lock_lost_q;
    assign STATE     = state_q;

endmodule
